// File: rtl/egress_ipg_scheduler_if.sv
// Bundle between the switch fabric, the egress PHY IPG side-channel and the scheduler.
// master = fabric/PHY side driving words and slots; slave = scheduler.
interface egress_ipg_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] rresp_data;
  logic                  rresp_valid;
  logic                  rresp_ready;
  logic [DATA_WIDTH-1:0] wreq_data;
  logic                  wreq_valid;
  logic                  wreq_ready;
  logic [DATA_WIDTH-1:0] rreq_data;
  logic                  rreq_valid;
  logic                  rreq_ready;
  logic                  ipg_slot;
  logic                  tx_ipg_en;
  logic [DATA_WIDTH-1:0] tx_ipg_data;
  logic [1:0]            tx_ipg_src;

  modport master (
    output rresp_data, rresp_valid, wreq_data, wreq_valid, rreq_data, rreq_valid, ipg_slot,
    input  rresp_ready, wreq_ready, rreq_ready, tx_ipg_en, tx_ipg_data, tx_ipg_src
  );

  modport slave (
    input  rresp_data, rresp_valid, wreq_data, wreq_valid, rreq_data, rreq_valid, ipg_slot,
    output rresp_ready, wreq_ready, rreq_ready, tx_ipg_en, tx_ipg_data, tx_ipg_src
  );
endinterface

// File: rtl/egress_ipg_scheduler.sv
// Per-port IPG scheduler: three class FIFOs, aged strict-priority pick on each IPG slot,
// registered output towards the egress PHY.
module egress_ipg_scheduler #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                   clk,
  input logic                   rst,
  egress_ipg_scheduler_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NumCls = 3;
  localparam logic [7:0]      Limit = 8'(STARVE_LIMIT);
  localparam logic [CntW-1:0] Full  = CntW'(FIFO_DEPTH);

  // Class index i carries source code i+1: 0 rreq, 1 wreq, 2 rresp.
  logic [DATA_WIDTH-1:0] mem_q [NumCls][FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q [NumCls];
  logic [PtrW-1:0]       wptr_d [NumCls];
  logic [PtrW-1:0]       rptr_q [NumCls];
  logic [PtrW-1:0]       rptr_d [NumCls];
  logic [CntW-1:0]       cnt_q  [NumCls];
  logic [CntW-1:0]       cnt_d  [NumCls];
  logic [7:0]            age_q  [2];
  logic [7:0]            age_d  [2];
  logic [DATA_WIDTH-1:0] in_data [NumCls];

  logic [NumCls-1:0]     in_valid, ready, push, grant, nonempty;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_src;

  logic                  tx_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [1:0]            tx_src_q;

  always_comb begin
    in_valid   = {bus.rresp_valid, bus.wreq_valid, bus.rreq_valid};
    in_data[0] = bus.rreq_data;
    in_data[1] = bus.wreq_data;
    in_data[2] = bus.rresp_data;
    for (int i = 0; i < NumCls; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      ready[i]    = (cnt_q[i] != Full) && !rst;
      push[i]     = in_valid[i] && ready[i];
    end
  end

  assign bus.rreq_ready  = ready[0];
  assign bus.wreq_ready  = ready[1];
  assign bus.rresp_ready = ready[2];

  always_comb begin
    grant = '0;
    if (bus.ipg_slot) begin
      if (nonempty[0] && age_q[0] == Limit)      grant[0] = 1'b1;
      else if (nonempty[1] && age_q[1] == Limit) grant[1] = 1'b1;
      else if (nonempty[2])                      grant[2] = 1'b1;
      else if (nonempty[1])                      grant[1] = 1'b1;
      else if (nonempty[0])                      grant[0] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_src  = 2'b00;
    for (int i = 0; i < NumCls; i++) begin
      wptr_d[i] = push[i]  ? wptr_q[i] + 1'b1 : wptr_q[i];
      rptr_d[i] = grant[i] ? rptr_q[i] + 1'b1 : rptr_q[i];
      cnt_d[i]  = cnt_q[i] + CntW'(push[i]) - CntW'(grant[i]);
      if (grant[i]) begin
        sel_data = mem_q[i][rptr_q[i]];
        sel_src  = 2'(i + 1);
      end
    end
  end

  // Only the two request classes age; saturation keeps them starved until served.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      age_d[j] = age_q[j];
      if (!nonempty[j]) begin
        age_d[j] = '0;
      end else if (bus.ipg_slot) begin
        if (grant[j])               age_d[j] = '0;
        else if (age_q[j] != Limit) age_d[j] = age_q[j] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumCls; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      for (int j = 0; j < 2; j++) age_q[j] <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      tx_src_q  <= 2'b00;
    end else begin
      for (int i = 0; i < NumCls; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      for (int j = 0; j < 2; j++) age_q[j] <= age_d[j];
      tx_en_q  <= |grant;
      tx_src_q <= sel_src;
      if (|grant) tx_data_q <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumCls; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i];
    end
  end

  assign bus.tx_ipg_en   = tx_en_q;
  assign bus.tx_ipg_data = tx_data_q;
  assign bus.tx_ipg_src  = tx_src_q;
endmodule

// File: tb/tb_egress_ipg_scheduler.sv
// Directed bench for egress_ipg_scheduler: vector table plus reset, starvation and
// mid-operation reset sequences.
module tb_egress_ipg_scheduler;
  localparam int unsigned DW = 64;
  localparam logic [63:0] A = 64'h123456781234561a;
  localparam logic [63:0] B = 64'h123456781234561b;
  localparam logic [63:0] E = 64'h123456781234561e;
  localparam logic [63:0] Q = 64'h00000000_0000a551;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  egress_ipg_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  egress_ipg_scheduler #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  v;     // {rresp, wreq, rreq}
    logic [63:0] rs_d;
    logic [63:0] wq_d;
    logic [63:0] rq_d;
    logic        slot;
    logic        en;
    logic [1:0]  src;
    logic [63:0] dat;
    logic [2:0]  rdy;   // {rresp, wreq, rreq}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] w(input int n);
    return 64'h00000000_00000b00 + 64'(n);
  endfunction

  function automatic logic [63:0] r(input int n);
    return 64'h52000000_00000000 + 64'(n);
  endfunction

  task automatic add(input logic [2:0] v, input logic [63:0] rs_d, input logic [63:0] wq_d,
                     input logic [63:0] rq_d, input logic slot, input logic en,
                     input logic [1:0] src, input logic [63:0] dat, input logic [2:0] rdy);
    vec_t x;
    x.v = v; x.rs_d = rs_d; x.wq_d = wq_d; x.rq_d = rq_d; x.slot = slot;
    x.en = en; x.src = src; x.dat = dat; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic set_in(input logic [2:0] v, input logic [63:0] rs_d, input logic [63:0] wq_d,
                        input logic [63:0] rq_d, input logic slot);
    bus.rresp_valid = v[2];
    bus.wreq_valid  = v[1];
    bus.rreq_valid  = v[0];
    bus.rresp_data  = rs_d;
    bus.wreq_data   = wq_d;
    bus.rreq_data   = rq_d;
    bus.ipg_slot    = slot;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] obs();
    return 128'({bus.tx_ipg_en, bus.tx_ipg_src, bus.tx_ipg_data,
                 bus.rresp_ready, bus.wreq_ready, bus.rreq_ready});
  endfunction

  function automatic logic [127:0] expv(input logic en, input logic [1:0] src,
                                        input logic [63:0] dat, input logic [2:0] rdy);
    return 128'({en, src, dat, rdy});
  endfunction

  initial begin
    // Single word, then fixed priority order.
    add(3'b001, 64'd0, 64'd0, A,     1'b1, 1'b0, 2'b00, 64'd0, 3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b01, A,     3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 2'b00, A,     3'b111);
    add(3'b111, E,     B,     A,     1'b0, 1'b0, 2'b00, A,     3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b11, E,     3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b10, B,     3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b01, A,     3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 2'b00, A,     3'b111);
    // Fill wreq to full with no slots; fifth word is held back.
    add(3'b010, 64'd0, w(1),  64'd0, 1'b0, 1'b0, 2'b00, A,     3'b111);
    add(3'b010, 64'd0, w(2),  64'd0, 1'b0, 1'b0, 2'b00, A,     3'b111);
    add(3'b010, 64'd0, w(3),  64'd0, 1'b0, 1'b0, 2'b00, A,     3'b111);
    add(3'b010, 64'd0, w(4),  64'd0, 1'b0, 1'b0, 2'b00, A,     3'b101);
    add(3'b010, 64'd0, w(5),  64'd0, 1'b0, 1'b0, 2'b00, A,     3'b101);
    add(3'b010, 64'd0, w(5),  64'd0, 1'b1, 1'b1, 2'b10, w(1),  3'b111);
    add(3'b010, 64'd0, w(5),  64'd0, 1'b1, 1'b1, 2'b10, w(2),  3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b10, w(3),  3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b10, w(4),  3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 2'b10, w(5),  3'b111);
    add(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 2'b00, w(5),  3'b111);

    // Reset held with every source offering a word.
    rst = 1'b1;
    set_in(3'b111, 64'hdead_0003, 64'hdead_0002, 64'hdead_0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_cycle%0d", i), obs(), expv(1'b0, 2'b00, 64'd0, 3'b000));
    end
    rst = 1'b0;
    set_in(3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
    #1;
    chk("ready_after_reset", obs(), expv(1'b0, 2'b00, 64'd0, 3'b111));

    foreach (vecs[i]) begin
      set_in(vecs[i].v, vecs[i].rs_d, vecs[i].wq_d, vecs[i].rq_d, vecs[i].slot);
      step();
      chk($sformatf("vec%0d", i), obs(),
          expv(vecs[i].en, vecs[i].src, vecs[i].dat, vecs[i].rdy));
    end

    // Starvation: rresp kept fed, one rreq waiting; rreq wins on the 9th slot.
    set_in(3'b101, r(0), 64'd0, Q, 1'b0);
    step();
    chk("starve_preload", 128'(bus.tx_ipg_en), 128'(1'b0));
    for (int n = 1; n <= 10; n++) begin
      logic [1:0]  es;
      logic [63:0] ed;
      set_in(3'b100, r(n), 64'd0, 64'd0, 1'b1);
      step();
      es = (n == 9) ? 2'b01 : 2'b11;
      ed = (n == 9) ? Q : ((n < 9) ? r(n - 1) : r(n - 2));
      chk($sformatf("starve_slot%0d", n), 128'({bus.tx_ipg_en, bus.tx_ipg_src, bus.tx_ipg_data}),
          128'({1'b1, es, ed}));
    end

    // Reset with words queued in every class: nothing may leak out afterwards.
    set_in(3'b111, 64'hfeed_0003, 64'hfeed_0002, 64'hfeed_0001, 1'b0);
    step();
    rst = 1'b1;
    set_in(3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
    step();
    chk("midreset_during", obs(), expv(1'b0, 2'b00, 64'd0, 3'b000));
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("midreset_slot%0d", i), obs(), expv(1'b0, 2'b00, 64'd0, 3'b111));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
